// File: rtl/qsys_multi_timer.sv
// qsys_multi_timer: NUM_CH independent prescaled down-counting timers behind one Avalon-MM slave,
// with per-channel snapshot, one-shot/continuous mode and maskable timeout interrupts.
module qsys_multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 32,
    parameter int PS_W = 8,
    parameter int DEFAULT_PERIOD = 99999,
    localparam int AW = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);
    logic          we;
    logic [2:0]    reg_sel;
    logic [AW-1:0] ch_sel;
    logic [31:0]   ch_rd [NUM_CH];
    logic [31:0]   rd_next;

    assign we = chipselect & ~write_n;
    assign reg_sel = address[2:0];
    assign ch_sel = address >> 3;
    assign irq = |irq_vec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] period, cnt, snap;
        logic [PS_W-1:0]  prescale, ps_cnt;
        logic             to, run, ito, cont;
        logic             wr, tick, expire;

        assign wr = we && ch_sel == AW'(g);
        assign tick = run && ps_cnt == '0;
        assign expire = tick && cnt == '0;
        assign irq_vec[g] = to & ito;
        assign ch_rd[g] = reg_sel == 3'd0 ? {30'b0, run, to} :
                          reg_sel == 3'd1 ? {30'b0, cont, ito} :
                          reg_sel == 3'd2 ? 32'(period) :
                          reg_sel == 3'd3 ? 32'(snap) :
                          reg_sel == 3'd4 ? 32'(prescale) : 32'b0;

        // Register writes come last so they override the counting updates in the same cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                period <= CNT_W'(DEFAULT_PERIOD);
                cnt <= CNT_W'(DEFAULT_PERIOD);
                snap <= '0;
                prescale <= '0;
                ps_cnt <= '0;
                to <= 1'b0;
                run <= 1'b0;
                ito <= 1'b0;
                cont <= 1'b0;
            end else begin
                to <= expire | (to & ~(wr && reg_sel == 3'd0));
                if (run) ps_cnt <= (ps_cnt == '0) ? prescale : ps_cnt - 1'b1;
                if (tick) cnt <= expire ? period : cnt - 1'b1;
                if (expire && !cont) run <= 1'b0;
                if (wr) begin
                    case (reg_sel)
                        3'd1: begin
                            ito <= writedata[0];
                            cont <= writedata[1];
                            if (writedata[3]) run <= 1'b0;
                            else if (writedata[2]) run <= 1'b1;
                        end
                        3'd2: begin
                            period <= writedata[CNT_W-1:0];
                            cnt <= writedata[CNT_W-1:0];
                            ps_cnt <= prescale;
                            run <= 1'b0;
                        end
                        3'd3: snap <= cnt;
                        3'd4: prescale <= writedata[PS_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int c = 0; c < NUM_CH; c++) rd_next = (ch_sel == AW'(c)) ? ch_rd[c] : rd_next;
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else readdata <= rd_next;
    end
endmodule

// File: tb/tb_qsys_multi_timer.sv
// tb_qsys_multi_timer: directed scenario tests for qsys_multi_timer with 4 channels.
module tb_qsys_multi_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    qsys_multi_timer dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        address = 5'(ch * 8 + r);
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        @(negedge clk);
        address = 5'(ch * 8 + r);
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_irq(input int ch, output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (irq_vec[ch]) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, exp;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        if (irq !== 1'b0 || irq_vec !== 4'b0) begin
            fails++;
            $display("FAIL reset_irq got irq=%b vec=%b expected 0/0000", irq, irq_vec);
        end
        checks++;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 8; r++) begin
                rd(ch, r, d);
                exp = (r == 2) ? 32'd99999 : 32'd0;
                if (d !== exp) begin
                    fails++;
                    $display("FAIL reset_reg ch%0d r%0d got %0d expected %0d", ch, r, d, exp);
                end
                checks++;
            end
        end
        wr(0, 5, 32'hffff_ffff);
        rd(0, 5, d);
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL reserved_write got %0h expected 0", d);
        end
        checks++;
    endtask

    task automatic test_continuous();
        int c0, t1, t2;
        wr(1, 4, 0);
        wr(1, 2, 9);
        wr(1, 1, 7);
        c0 = cyc;
        wait_irq(1, t1);
        if (t1 - c0 !== 10 || t1 < 0) begin
            fails++;
            $display("FAIL ch1_first_to got %0d cycles expected 10", t1 - c0);
        end
        checks++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL ch1_irq got %b expected 1", irq);
        end
        checks++;
        wr(1, 0, 0);
        if (irq_vec[1] !== 1'b0) begin
            fails++;
            $display("FAIL ch1_clear got %b expected 0", irq_vec[1]);
        end
        checks++;
        wait_irq(1, t2);
        if (t2 - t1 !== 10 || t2 < 0) begin
            fails++;
            $display("FAIL ch1_second_to got %0d cycles expected 10", t2 - t1);
        end
        checks++;
        wr(1, 1, 8);
        wr(1, 0, 0);
    endtask

    task automatic test_one_shot();
        int c0, t;
        logic [31:0] d;
        wr(2, 4, 4);
        wr(2, 2, 3);
        wr(2, 1, 5);
        c0 = cyc;
        wait_irq(2, t);
        if (t - c0 !== 20 || t < 0) begin
            fails++;
            $display("FAIL ch2_one_shot got %0d cycles expected 20", t - c0);
        end
        checks++;
        rd(2, 0, d);
        if (d !== 32'd1) begin
            fails++;
            $display("FAIL ch2_status got %0h expected 1", d);
        end
        checks++;
        wr(2, 3, 0);
        rd(2, 3, d);
        if (d !== 32'd3) begin
            fails++;
            $display("FAIL ch2_hold got %0d expected 3", d);
        end
        checks++;
        wr(2, 1, 0);
        wr(2, 0, 0);
    endtask

    task automatic test_clear_collision();
        logic [31:0] d;
        wr(0, 4, 0);
        wr(0, 2, 4);
        wr(0, 1, 7);
        repeat (6) @(negedge clk);
        address = 5'd0;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        if (irq_vec[0] !== 1'b0) begin
            fails++;
            $display("FAIL ch0_clear got %b expected 0", irq_vec[0]);
        end
        checks++;
        repeat (2) @(negedge clk);
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        if (irq_vec[0] !== 1'b1) begin
            fails++;
            $display("FAIL ch0_set_wins got %b expected 1", irq_vec[0]);
        end
        checks++;
        wr(0, 1, 12);
        rd(0, 0, d);
        if (d !== 32'd1) begin
            fails++;
            $display("FAIL ch0_stop_wins got %0h expected 1", d);
        end
        checks++;
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        wr(3, 4, 0);
        wr(3, 2, 1000);
        wr(3, 1, 4);
        repeat (49) @(negedge clk);
        address = 5'(3 * 8 + 3);
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        rd(3, 3, d);
        if (d !== 32'd951) begin
            fails++;
            $display("FAIL ch3_snap got %0d expected 951", d);
        end
        checks++;
        wr(3, 2, 500);
        rd(3, 0, d);
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL ch3_period_stop got %0h expected 0", d);
        end
        checks++;
        wr(3, 3, 0);
        rd(3, 3, d);
        if (d !== 32'd500) begin
            fails++;
            $display("FAIL ch3_period_reload got %0d expected 500", d);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        wr(0, 2, 6);
        wr(0, 0, 0);
        wr(0, 1, 1);
        wr(3, 2, 4);
        wr(3, 0, 0);
        wr(3, 1, 1);
        wr(0, 1, 5);
        wr(3, 1, 5);
        repeat (4) @(negedge clk);
        if (irq_vec !== 4'b0000) begin
            fails++;
            $display("FAIL early_irq got %b expected 0000", irq_vec);
        end
        checks++;
        @(negedge clk);
        if (irq_vec !== 4'b1001 || irq !== 1'b1) begin
            fails++;
            $display("FAIL same_cycle_to got vec=%b irq=%b expected 1001/1", irq_vec, irq);
        end
        checks++;
        wr(0, 0, 0);
        if (irq_vec !== 4'b1000 || irq !== 1'b1) begin
            fails++;
            $display("FAIL clear_ch0 got vec=%b irq=%b expected 1000/1", irq_vec, irq);
        end
        checks++;
    endtask

    task automatic test_mid_reset();
        wr(1, 4, 0);
        wr(1, 2, 20);
        wr(1, 1, 7);
        repeat (25) @(negedge clk);
        if (irq_vec !== 4'b1010) begin
            fails++;
            $display("FAIL pre_reset got %b expected 1010", irq_vec);
        end
        checks++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if (irq_vec !== 4'b0 || irq !== 1'b0 || readdata !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset got vec=%b irq=%b rd=%0h expected 0000/0/0", irq_vec, irq, readdata);
        end
        checks++;
        test_reset();
    endtask

    initial begin
        reset = 1'b1;
        address = '0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        test_reset();
        test_continuous();
        test_one_shot();
        test_clear_collision();
        test_snapshot();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
